// File: rtl/gp_rect_engine.sv
// Rectangle graphics engine: solid fill or sprite blit of one clamped rectangle
// into a row-major 12-bit frame buffer. Handshake is four-phase gp_en/gp_finish.
module gp_rect_engine #(
  parameter int          H_RES       = 640,
  parameter int          V_RES       = 480,
  parameter int          ROM_AW      = 16,
  parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gp_en,
  input  logic              gp_opcode,
  input  logic [9:0]        gp_tl_x,
  input  logic [8:0]        gp_tl_y,
  input  logic [9:0]        gp_br_x,
  input  logic [8:0]        gp_br_y,
  input  logic [11:0]       gp_arg,
  output logic              gp_finish,
  output logic              vram_we,
  output logic [18:0]       vram_addr,
  output logic [11:0]       vram_din,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [11:0]       rom_dout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_BLIT  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [9:0]  X_MAX = 10'(H_RES - 1);
  localparam logic [8:0]  Y_MAX = 9'(V_RES - 1);
  localparam logic [18:0] PITCH = 19'(H_RES);

  function automatic logic [9:0] sat_x(input logic [9:0] v);
    return (v > X_MAX) ? X_MAX : v;
  endfunction

  function automatic logic [8:0] sat_y(input logic [8:0] v);
    return (v > Y_MAX) ? Y_MAX : v;
  endfunction

  logic [2:0]  state;
  logic [9:0]  x, tl_x, br_x;
  logic [8:0]  y, br_y;
  logic [18:0] row_base;
  logic [11:0] colour;
  logic [18:0] addr_p1;
  logic        vld_p1;
  logic [9:0]  br_x_c;
  logic [8:0]  br_y_c;
  logic        cmd_bad;
  logic        last_px;
  logic        accept;

  assign br_x_c    = sat_x(gp_br_x);
  assign br_y_c    = sat_y(gp_br_y);
  assign cmd_bad   = (gp_tl_x > br_x_c) || (gp_tl_y > br_y_c) ||
                     (gp_tl_x > X_MAX) || (gp_tl_y > Y_MAX);
  assign accept    = (state == S_IDLE) && gp_en && !gp_finish;
  assign last_px   = (x == br_x) && (y == br_y);
  assign gp_finish = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      vld_p1   <= 1'b0;
      rom_addr <= '0;
    end else begin
      vld_p1 <= (state == S_BLIT);
      case (state)
        S_IDLE: begin
          if (accept) begin
            rom_addr <= ROM_AW'(gp_arg);
            if (cmd_bad)        state <= S_DONE;
            else if (gp_opcode) state <= S_BLIT;
            else                state <= S_FILL;
          end
        end
        S_FILL:  if (last_px) state <= S_DONE;
        S_BLIT: begin
          rom_addr <= rom_addr + ROM_AW'(1);
          if (last_px) state <= S_FLUSH;
        end
        S_FLUSH: state <= S_DONE;
        S_DONE:  if (!gp_en) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p0: raster walk; row_base tracks y*H_RES by repeated addition
  always_ff @(posedge clk) begin
    if (accept) begin
      tl_x     <= gp_tl_x;
      br_x     <= br_x_c;
      br_y     <= br_y_c;
      colour   <= gp_arg;
      x        <= gp_tl_x;
      y        <= gp_tl_y;
      row_base <= 19'(gp_tl_y) * PITCH;
    end else if ((state == S_FILL) || (state == S_BLIT)) begin
      if (x == br_x) begin
        x        <= tl_x;
        y        <= y + 9'd1;
        row_base <= row_base + PITCH;
      end else begin
        x <= x + 10'd1;
      end
    end
  end

  // Stage p1: pixel address delayed to line up with synchronous ROM data
  always_ff @(posedge clk) begin
    addr_p1 <= row_base + 19'(x);
  end

  always_comb begin
    vram_we   = 1'b0;
    vram_addr = '0;
    vram_din  = '0;
    if (state == S_FILL) begin
      vram_we   = 1'b1;
      vram_addr = row_base + 19'(x);
      vram_din  = colour;
    end else if (vld_p1) begin
      vram_we   = (rom_dout != TRANSPARENT);
      vram_addr = addr_p1;
      vram_din  = rom_dout;
    end
  end

endmodule

// File: tb/tb_gp_rect_engine.sv
// Bench for gp_rect_engine: directed and random rectangle commands against a
// raster-loop reference model, with a synchronous sprite ROM and a write monitor.
module tb_gp_rect_engine;
  localparam int          H_RES       = 640;
  localparam int          V_RES       = 480;
  localparam int          ROM_AW      = 16;
  localparam logic [11:0] TRANSPARENT = 12'hF0F;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              gp_en = 1'b0;
  logic              gp_opcode = 1'b0;
  logic [9:0]        gp_tl_x = '0;
  logic [8:0]        gp_tl_y = '0;
  logic [9:0]        gp_br_x = '0;
  logic [8:0]        gp_br_y = '0;
  logic [11:0]       gp_arg = '0;
  logic              gp_finish;
  logic              vram_we;
  logic [18:0]       vram_addr;
  logic [11:0]       vram_din;
  logic [ROM_AW-1:0] rom_addr;
  logic [11:0]       rom_dout = '0;

  gp_rect_engine #(.H_RES(H_RES), .V_RES(V_RES), .ROM_AW(ROM_AW), .TRANSPARENT(TRANSPARENT)) dut (
    .clk(clk), .rst_n(rst_n), .gp_en(gp_en), .gp_opcode(gp_opcode),
    .gp_tl_x(gp_tl_x), .gp_tl_y(gp_tl_y), .gp_br_x(gp_br_x), .gp_br_y(gp_br_y),
    .gp_arg(gp_arg), .gp_finish(gp_finish), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_din(vram_din), .rom_addr(rom_addr), .rom_dout(rom_dout)
  );

  always #5 clk = ~clk;

  logic [11:0] rom [0:(1<<ROM_AW)-1];
  always @(posedge clk) rom_dout <= rom[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: a write seen now is captured by VRAM at the next rising edge
  int unsigned wr_addr_q[$];
  logic [11:0] wr_data_q[$];
  int          wr_edge_q[$];
  always @(negedge clk) begin
    if (vram_we) begin
      wr_addr_q.push_back(vram_addr);
      wr_data_q.push_back(vram_din);
      wr_edge_q.push_back(cyc + 1);
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: expected writes (address, data, edge offset from N) and finish offset
  int unsigned ex_addr[$];
  logic [11:0] ex_data[$];
  int          ex_off[$];
  int          ex_fin;
  int          ex_rom[$];

  task automatic build_exp(input bit op, input int tlx, input int tly, input int brx,
                           input int bry, input int arg);
    int k;
    logic [11:0] d;
    ex_addr.delete(); ex_data.delete(); ex_off.delete(); ex_rom.delete();
    if (brx > H_RES - 1) brx = H_RES - 1;
    if (bry > V_RES - 1) bry = V_RES - 1;
    if (tlx > brx || tly > bry || tlx >= H_RES || tly >= V_RES) begin
      ex_fin = 1;
      return;
    end
    k = 0;
    for (int yy = tly; yy <= bry; yy++) begin
      for (int xx = tlx; xx <= brx; xx++) begin
        if (!op) begin
          ex_addr.push_back(yy * H_RES + xx);
          ex_data.push_back(12'(arg));
          ex_off.push_back(1 + k);
        end else begin
          ex_rom.push_back((arg + k) % (1 << ROM_AW));
          d = rom[(arg + k) % (1 << ROM_AW)];
          if (d != TRANSPARENT) begin
            ex_addr.push_back(yy * H_RES + xx);
            ex_data.push_back(d);
            ex_off.push_back(2 + k);
          end
        end
        k++;
      end
    end
    ex_fin = op ? k + 2 : k + 1;
  endtask

  task automatic run_cmd(input string tag, input bit op, input int tlx, input int tly,
                         input int brx, input int bry, input int arg, input int drop_at);
    int n0, fin_edge, n;
    int unsigned rom_seen[$];
    build_exp(op, tlx, tly, brx, bry, arg);
    @(negedge clk);
    wr_addr_q.delete(); wr_data_q.delete(); wr_edge_q.delete();
    gp_opcode = op;
    gp_tl_x = 10'(tlx); gp_tl_y = 9'(tly);
    gp_br_x = 10'(brx); gp_br_y = 9'(bry);
    gp_arg = 12'(arg);
    gp_en = 1'b1;
    n0 = cyc + 1;
    fin_edge = -1;
    for (int i = 0; i < ex_fin + 50 && fin_edge < 0; i++) begin
      @(negedge clk);
      if (op && ex_rom.size() <= 8 && i < ex_rom.size()) rom_seen.push_back(rom_addr);
      if (gp_finish) fin_edge = cyc + 1 - n0;
      else begin
        gp_opcode = 1'($urandom); gp_arg = 12'($urandom);
        gp_tl_x = 10'($urandom); gp_tl_y = 9'($urandom);
        gp_br_x = 10'($urandom); gp_br_y = 9'($urandom);
      end
      if (drop_at > 0 && cyc + 1 - n0 == drop_at) gp_en = 1'b0;
    end
    chk({tag, " finish_latency"}, fin_edge, ex_fin);
    chk({tag, " write_count"}, wr_addr_q.size(), ex_addr.size());
    n = (wr_addr_q.size() < ex_addr.size()) ? wr_addr_q.size() : ex_addr.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, " addr"}, wr_addr_q[i], ex_addr[i]);
      chk({tag, " data"}, wr_data_q[i], ex_data[i]);
      chk({tag, " write_edge"}, wr_edge_q[i] - n0, ex_off[i]);
    end
    for (int i = 0; i < rom_seen.size(); i++) chk({tag, " rom_addr"}, rom_seen[i], ex_rom[i]);
    if (drop_at > 0) begin
      @(negedge clk);
      chk({tag, " finish_pulse_end"}, gp_finish, 1'b0);
    end else begin
      @(negedge clk);
      chk({tag, " finish_held"}, gp_finish, 1'b1);
      gp_en = 1'b0;
      @(negedge clk);
      chk({tag, " finish_drop"}, gp_finish, 1'b0);
    end
    chk({tag, " idle_we"}, vram_we, 1'b0);
  endtask

  task automatic reset_mid_fill();
    int sz;
    @(negedge clk);
    wr_addr_q.delete(); wr_data_q.delete(); wr_edge_q.delete();
    gp_opcode = 1'b0; gp_tl_x = 10'd0; gp_tl_y = 9'd0;
    gp_br_x = 10'd99; gp_br_y = 9'd9; gp_arg = 12'hABC; gp_en = 1'b1;
    for (int i = 0; i < 500 && wr_addr_q.size() < 100; i++) @(negedge clk);
    rst_n = 1'b0;
    gp_en = 1'b0;
    #1;
    chk("rst_mid we", vram_we, 1'b0);
    chk("rst_mid finish", gp_finish, 1'b0);
    chk("rst_mid rom_addr", rom_addr, '0);
    chk("rst_mid vram_addr", vram_addr, '0);
    sz = wr_addr_q.size();
    repeat (3) @(negedge clk);
    chk("rst_mid no_writes", wr_addr_q.size(), sz);
    rst_n = 1'b1;
  endtask

  initial begin
    int tlx, tly, w, h;
    for (int i = 0; i < (1 << ROM_AW); i++)
      rom[i] = ($urandom_range(0, 7) == 0) ? TRANSPARENT : 12'($urandom);
    rom[16'h100] = 12'h123; rom[16'h101] = 12'hF0F;
    rom[16'h102] = 12'h456; rom[16'h103] = 12'h789;

    #1;
    chk("reset finish", gp_finish, 1'b0);
    chk("reset we", vram_we, 1'b0);
    chk("reset vram_addr", vram_addr, '0);
    chk("reset vram_din", vram_din, '0);
    chk("reset rom_addr", rom_addr, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_cmd("fill_small", 1'b0, 2, 3, 4, 4, 12'h0F0, 0);
    run_cmd("blit_small", 1'b1, 10, 0, 11, 1, 12'h100, 0);
    run_cmd("degen_x", 1'b0, 5, 0, 4, 3, 12'h111, 0);
    run_cmd("degen_y", 1'b1, 0, 9, 3, 8, 12'h222, 0);
    run_cmd("tl_y_off", 1'b0, 0, 500, 3, 510, 12'h333, 0);
    run_cmd("tl_x_off", 1'b0, 700, 0, 800, 1, 12'h444, 0);
    run_cmd("clamp_x", 1'b0, 630, 10, 700, 11, 12'h555, 0);
    run_cmd("clamp_xy_blit", 1'b1, 636, 476, 1000, 511, 12'h7F0, 0);
    run_cmd("drop_early", 1'b0, 0, 0, 19, 0, 12'h0AA, 3);
    run_cmd("drop_early_blit", 1'b1, 100, 100, 104, 101, 12'h010, 3);
    run_cmd("fill_top_rows", 1'b0, 0, 0, 639, 19, 12'hFFF, 0);
    run_cmd("fill_bottom_rows", 1'b0, 0, 470, 639, 479, 12'hFFF, 0);

    reset_mid_fill();
    run_cmd("after_reset", 1'b0, 7, 7, 9, 8, 12'h321, 0);

    for (int t = 0; t < 24; t++) begin
      tlx = $urandom_range(0, 639);
      tly = $urandom_range(0, 479);
      w = $urandom_range(1, 16);
      h = $urandom_range(1, 8);
      if ($urandom_range(0, 7) == 0) run_cmd("rand_degen", 1'($urandom), tlx, tly, tlx - 1 + (tlx == 0 ? 2 : 0) * 0, tly, $urandom_range(0, 4095), 0);
      else run_cmd("rand", 1'($urandom), tlx, tly, tlx + w - 1, tly + h - 1, $urandom_range(0, 4095), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gp_rect_engine.md
Name: gp_rect_engine

Overview:
- Graphics processor that executes one rectangle command from the game controller and writes the pixels into the 640x480, 12-bit-colour frame buffer.
- Opcode 0 fills the rectangle with a solid colour.
- Opcode 1 blits a sprite, row-major, from sprite ROM starting at a base address.
- Sits between the game controller (command side, four-phase en/finish handshake) and the VRAM write port.

Parameters:
- H_RES, 640, frame width in pixels; row pitch of VRAM.
- V_RES, 480, frame height in pixels.
- ROM_AW, 16, sprite ROM address width.
- TRANSPARENT, 12'hF0F, sprite colour that is skipped (no write).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- gp_en  in  1  command request; held high until gp_finish is seen.
- gp_opcode  in  1  0 = solid fill, 1 = sprite blit.
- gp_tl_x  in  10  top-left x.
- gp_tl_y  in  9  top-left y.
- gp_br_x  in  10  bottom-right x, inclusive.
- gp_br_y  in  9  bottom-right y, inclusive.
- gp_arg  in  12  fill colour (op 0) or ROM base address (op 1, zero-extended to ROM_AW).
- gp_finish  out  1  command complete; level, held while gp_en high.
- vram_we  out  1  VRAM write strobe.
- vram_addr  out  19  VRAM address = y*H_RES + x.
- vram_din  out  12  pixel colour.
- rom_addr  out  ROM_AW  sprite ROM read address.
- rom_dout  in  12  sprite ROM data, valid 1 cycle after rom_addr (synchronous ROM).

Behaviour:
- Reset (async, rst_n low): state IDLE. gp_finish, vram_we = 0. vram_addr, vram_din, rom_addr = 0. Reset mid-command aborts immediately; no further writes.
- States:
  - IDLE: on gp_en=1 && gp_finish=0, latch all command fields. Clamp br_x to H_RES-1 and br_y to V_RES-1. Set x=tl_x, y=tl_y, row_base=tl_y*H_RES (one multiply at latch time; incremental add of H_RES thereafter), rom_addr=arg.
    - If tl_x>br_x or tl_y>br_y (after clamp) or tl_x>=H_RES or tl_y>=V_RES -> DONE with zero writes.
    - Else opcode 0 -> FILL, opcode 1 -> BLIT.
  - FILL: one write per cycle. vram_we=1, vram_addr=row_base+x, vram_din=colour. Advance x; at x==br_x wrap x to tl_x, y+1, row_base+=H_RES. After the write of (br_x,br_y) -> DONE.
  - BLIT: issue rom_addr each cycle, incrementing by 1 per pixel (wraps modulo 2^ROM_AW). Pixel address pipelined one stage to align with rom_dout. Write next cycle with vram_din=rom_dout and vram_we=1 unless rom_dout==TRANSPARENT. After the last address is issued -> FLUSH.
  - FLUSH: perform the final pipelined write (or skip it if transparent) -> DONE.
  - DONE: gp_finish=1, vram_we=0. Stay until gp_en=0, then gp_finish=0 -> IDLE next cycle.
- Latency, with gp_en sampled high at edge N:
  - Fill: first write at N+1; last write at N+W*H.
  - Blit: first write at N+2.
  - gp_finish rises the cycle after the last write slot.
- Command inputs are ignored outside IDLE; changing them mid-command has no effect.
- gp_en dropping before DONE does not abort; the command completes, gp_finish pulses for one cycle, then IDLE.
- gp_en high in IDLE with gp_finish=1 cannot occur (DONE owns that).
- Any new command starts only from IDLE.
- No output is ever X after reset. vram_addr stays < H_RES*V_RES whenever vram_we=1.

Test Plan:
- Full-screen white fill (0,0)-(639,479), arg 12'hFFF:
  - exactly 307200 writes, addresses 0..307199 in order, all data FFF;
  - gp_finish high at N+307201;
  - gp_finish low one cycle after gp_en drops.
- Fill (2,3)-(4,4), colour 12'h0F0 -> 6 writes to addresses 1922, 1923, 1924, 2562, 2563, 2564, then finish.
- Blit (10,0)-(11,1), base 0x0100, ROM[0x100..0x103] = {123, F0F, 456, 789}:
  - rom_addr 100, 101, 102, 103;
  - writes: addr 10 = 123, addr 650 = 456, addr 651 = 789;
  - no write to addr 11.
- Degenerate rectangles:
  - tl_x=5, br_x=4 -> zero writes, finish at N+1.
  - br_x=700 -> clamped; last write x=639.
- Reset asserted mid-fill (after 100 writes) -> vram_we=0 immediately, gp_finish=0; a new command after reset runs normally.
- gp_en deasserted at N+3 during a 20-pixel fill -> all 20 writes occur, gp_finish pulses one cycle, then IDLE.
